usbdev_line_monitor: RTL
========================

USBDEV_LINE_MONITOR -- requirements
Module: usbdev_line_monitor

Interface
REQ-001 SHALL have parameter ResetUs, default 3, meaning continuous SE0 time in microseconds that constitutes a bus reset.
REQ-002 SHALL have parameter SuspendUs, default 3000, meaning continuous J/idle time in microseconds that constitutes suspend.
REQ-003 SHALL have parameter LineDebounce, default 3, meaning clk_i cycles a new line state must persist before acceptance.
REQ-004 SHALL have port clk_i  input  1  USB clock; single clock domain.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port us_tick_i  input  1  one-cycle pulse once per microsecond.
REQ-007 SHALL have port rx_dp_i  input  1  synchronized D+ from the IO mux.
REQ-008 SHALL have port rx_dn_i  input  1  synchronized D- from the IO mux.
REQ-009 SHALL have port pwr_sense_i  input  1  synchronized VBUS sense from the IO mux.
REQ-010 SHALL have port line_state_o  output  2  debounced line state: 0 SE0, 1 J (dp=1,dn=0), 2 K, 3 SE1.
REQ-011 SHALL have port link_state_o  output  3  link FSM state encoding (see REQ-018).
REQ-012 SHALL have port bus_reset_o  output  1  level, high while in LINK_RESET.
REQ-013 SHALL have port evt_reset_o, evt_suspend_o, evt_resume_o, evt_disconnect_o, evt_powered_o  output  1 each  single-cycle event pulses.

Function
REQ-014 Raw state SHALL be {dn,dp} mapped per REQ-010; line_state_o SHALL update only after the raw value has been identical for LineDebounce consecutive cycles.
REQ-015 Latency from a stable raw change to line_state_o change SHALL be exactly LineDebounce cycles; glitches shorter than that SHALL not propagate.
REQ-016 A microsecond counter (width clog2(SuspendUs+1)) SHALL clear whenever line_state_o changes and increment on us_tick_i, saturating at SuspendUs.
REQ-017 A tick coinciding with a line-state change SHALL clear, not increment, the counter.
REQ-018 Link FSM states SHALL be DISCONNECTED(0), POWERED(1), RESET(2), ACTIVE(3), SUSPENDED(4).
REQ-019 DISCONNECTED -> POWERED when pwr_sense_i=1; evt_powered_o pulses on that transition.
REQ-020 Any state except DISCONNECTED -> DISCONNECTED when pwr_sense_i=0, with evt_disconnect_o; this has priority over all other transitions in the same cycle.
REQ-021 POWERED, ACTIVE or SUSPENDED -> RESET when line_state_o=SE0 and counter reaches ResetUs; evt_reset_o pulses once on entry.
REQ-022 RESET -> ACTIVE when line_state_o leaves SE0.
REQ-023 ACTIVE -> SUSPENDED when line_state_o=J and counter reaches SuspendUs; evt_suspend_o pulses once.
REQ-024 SUSPENDED -> ACTIVE when line_state_o becomes K, with evt_resume_o; SE0 in SUSPENDED SHALL instead follow REQ-021 (no resume event).
REQ-025 SE1 SHALL be treated as non-idle (clears counter) and SHALL cause no transition.
REQ-026 At most one event output SHALL be high in any cycle; events SHALL be registered outputs.

Reset
REQ-027 On rst_ni low: line_state_o=0 (SE0), link_state_o=DISCONNECTED, bus_reset_o=0, all events 0, counters 0, debounce history 0.
REQ-028 Reset asserted mid-operation SHALL abort any state immediately; after release the FSM SHALL re-evaluate pwr_sense_i from DISCONNECTED.

Structure
REQ-029 Link-state enum and line-state encodings SHALL live in usbdev_pkg for reuse by usbdev_reg_top and the USB engine.
REQ-030 Debounce SHALL be a sub-module usbdev_line_debounce (width 2, parameter LineDebounce); FSM and counter remain in the top.

Verification
REQ-031 pwr_sense_i 0->1 -> evt_powered_o one pulse, link_state_o=1; then 0 -> evt_disconnect_o, link_state_o=0.
REQ-032 In POWERED, SE0 held 3 us -> evt_reset_o at the 3rd tick after debounced SE0, bus_reset_o=1; J restored -> link_state_o=3 after 3 cycles.
REQ-033 In ACTIVE, J held 3000 ticks -> evt_suspend_o once, link_state_o=4; then K -> evt_resume_o, link_state_o=3.
REQ-034 Raw line toggled to K for 2 cycles only -> line_state_o unchanged, counter not cleared.
REQ-035 pwr_sense_i dropped in the same cycle the suspend threshold is reached -> only evt_disconnect_o, link_state_o=0.
REQ-036 rst_ni asserted while in SUSPENDED -> all outputs at REQ-027 values asynchronously, before next clk_i edge.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared USB device encodings: debounced line states, link FSM states and
// the link event bundle. Also used by the register top and the USB engine.
package usbdev_pkg;

    // Line state is the raw pair {dn, dp}.
    typedef enum logic [1:0] {
        LINE_SE0 = 2'd0,
        LINE_J   = 2'd1,  // dp=1, dn=0
        LINE_K   = 2'd2,  // dp=0, dn=1
        LINE_SE1 = 2'd3
    } line_state_e;

    typedef enum logic [2:0] {
        LINK_DISCONNECTED = 3'd0,
        LINK_POWERED      = 3'd1,
        LINK_RESET        = 3'd2,
        LINK_ACTIVE       = 3'd3,
        LINK_SUSPENDED    = 3'd4
    } link_state_e;

    typedef struct packed {
        logic reset;
        logic suspend;
        logic resume;
        logic disconnect;
        logic powered;
    } link_evt_t;

endpackage

// File: rtl/usbdev_line_debounce.sv
// Debounces a Width-bit bus: q_o takes d_i once d_i has been sampled
// identical on LineDebounce consecutive clocks, so a stable change shows up
// exactly LineDebounce cycles later and shorter glitches are dropped.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   d_i            raw input
//   q_o            debounced value (resets to 0)
//   chg_o          high in the cycle whose clock edge will change q_o
module usbdev_line_debounce #(
    parameter int Width        = 2,
    parameter int LineDebounce = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic             chg_o
);

    localparam int CntW = (LineDebounce < 2) ? 1 : $clog2(LineDebounce + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LineDebounce);

    logic [Width-1:0] prev_q, q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // cnt_d is the run length of identical samples including the current
    // one, saturating at LineDebounce.
    always_comb begin
        if (d_i != prev_q)       cnt_d = CntW'(1);
        else if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        else                     cnt_d = cnt_q;
        q_d   = (cnt_d == CntMax) ? d_i : q_q;
        chg_o = (q_d != q_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
        end else begin
            prev_q <= d_i;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/usbdev_line_monitor.sv
// USB device line monitor: debounces D+/D-, times how long the debounced
// line has been steady in microseconds, and runs the link FSM that detects
// power, bus reset, suspend, resume and disconnect.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   us_tick_i                  one-cycle pulse per microsecond
//   rx_dp_i, rx_dn_i           synchronized bus lines
//   pwr_sense_i                synchronized VBUS sense
//   line_state_o               debounced line state (line_state_e)
//   link_state_o               link FSM state (link_state_e)
//   bus_reset_o                high while in LINK_RESET
//   evt_*_o                    registered single-cycle event pulses
module usbdev_line_monitor
    import usbdev_pkg::*;
#(
    parameter int ResetUs      = 3,
    parameter int SuspendUs    = 3000,
    parameter int LineDebounce = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       us_tick_i,
    input  logic       rx_dp_i,
    input  logic       rx_dn_i,
    input  logic       pwr_sense_i,
    output logic [1:0] line_state_o,
    output logic [2:0] link_state_o,
    output logic       bus_reset_o,
    output logic       evt_reset_o,
    output logic       evt_suspend_o,
    output logic       evt_resume_o,
    output logic       evt_disconnect_o,
    output logic       evt_powered_o
);

    localparam int UsW = $clog2(SuspendUs + 1);
    localparam logic [UsW-1:0] UsMax = UsW'(SuspendUs);
    localparam logic [UsW-1:0] UsRst = UsW'(ResetUs);

    logic [1:0]  line_raw;
    line_state_e line;
    logic        line_chg;

    usbdev_line_debounce #(
        .Width        (2),
        .LineDebounce (LineDebounce)
    ) u_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({rx_dn_i, rx_dp_i}),
        .q_o    (line_raw),
        .chg_o  (line_chg)
    );

    assign line = line_state_e'(line_raw);

    // Time since the debounced line last changed. A line change wins over a
    // coincident tick so every state starts timing from zero.
    logic [UsW-1:0] us_q, us_d;

    always_comb begin
        if (line_chg)                     us_d = '0;
        else if (us_tick_i && us_q != UsMax) us_d = us_q + UsW'(1);
        else                              us_d = us_q;
    end

    link_state_e state_q, state_d;
    link_evt_t   evt_q, evt_d;

    always_comb begin
        state_d = state_q;
        evt_d   = '0;
        // Losing VBUS overrides every other transition.
        if (state_q != LINK_DISCONNECTED && !pwr_sense_i) begin
            state_d          = LINK_DISCONNECTED;
            evt_d.disconnect = 1'b1;
        end else begin
            case (state_q)
                LINK_DISCONNECTED: begin
                    if (pwr_sense_i) begin
                        state_d       = LINK_POWERED;
                        evt_d.powered = 1'b1;
                    end
                end
                LINK_POWERED, LINK_ACTIVE, LINK_SUSPENDED: begin
                    if (line == LINE_SE0 && us_q >= UsRst) begin
                        state_d     = LINK_RESET;
                        evt_d.reset = 1'b1;
                    end else if (state_q == LINK_ACTIVE && line == LINE_J &&
                                 us_q == UsMax) begin
                        state_d       = LINK_SUSPENDED;
                        evt_d.suspend = 1'b1;
                    end else if (state_q == LINK_SUSPENDED && line == LINE_K) begin
                        state_d      = LINK_ACTIVE;
                        evt_d.resume = 1'b1;
                    end
                end
                // SE1 is not a valid way out of reset; wait for J or K.
                LINK_RESET: begin
                    if (line == LINE_J || line == LINE_K) state_d = LINK_ACTIVE;
                end
                default: state_d = LINK_DISCONNECTED;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            us_q    <= '0;
            state_q <= LINK_DISCONNECTED;
            evt_q   <= '0;
        end else begin
            us_q    <= us_d;
            state_q <= state_d;
            evt_q   <= evt_d;
        end
    end

    assign line_state_o     = line_raw;
    assign link_state_o     = state_q;
    assign bus_reset_o      = (state_q == LINK_RESET);
    assign evt_reset_o      = evt_q.reset;
    assign evt_suspend_o    = evt_q.suspend;
    assign evt_resume_o     = evt_q.resume;
    assign evt_disconnect_o = evt_q.disconnect;
    assign evt_powered_o    = evt_q.powered;

endmodule
